// File: rtl/ace_snoop_pkg.sv
// ace_snoop_pkg: shared constants, state encoding and timeout width for the ACE snoop collector
package ace_snoop_pkg;
    localparam int unsigned CR_DT  = 0;
    localparam int unsigned CR_ERR = 1;
    localparam int unsigned CR_PD  = 2;
    localparam int unsigned CR_IS  = 3;
    localparam int unsigned CR_WU  = 4;
    localparam int unsigned TO_W   = 16;
    typedef enum logic [1:0] {IDLE, SEND_AC, FWD_CD, RESP} state_e;
endpackage

// File: rtl/ace_snoop_lzc_sel.sv
// ace_snoop_lzc_sel: isolates the lowest set bit of a vector and encodes its index
module ace_snoop_lzc_sel #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx
);
    assign onehot = vec & (~vec + N'(1));
    // scan from the top so the lowest set index is the one that sticks
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (vec[i]) idx = W'(i);
    end
endmodule

// File: rtl/ace_snoop_collector.sv
// ace_snoop_collector: broadcasts one snoop, merges CR responses, forwards one CD line (ACE_SNOOP_TIMEOUT_EN adds a 16-bit timeout)
module ace_snoop_collector
    import ace_snoop_pkg::*;
#(
    parameter int NoPorts = 4,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int LineWidth = 512,
    parameter bit SkipInitiator = 1'b1,
    localparam int IW = $clog2(NoPorts)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [AddrWidth-1:0]           req_addr_i,
    input  logic [3:0]                     req_snoop_i,
    input  logic [IW-1:0]                  req_src_i,
    input  logic [NoPorts-1:0]             req_mask_i,
    output logic [NoPorts-1:0]             ac_valid_o,
    input  logic [NoPorts-1:0]             ac_ready_i,
    output logic [AddrWidth-1:0]           ac_addr_o,
    output logic [3:0]                     ac_snoop_o,
    input  logic [NoPorts-1:0]             cr_valid_i,
    output logic [NoPorts-1:0]             cr_ready_o,
    input  logic [5*NoPorts-1:0]           cr_resp_i,
    input  logic [NoPorts-1:0]             cd_valid_i,
    output logic [NoPorts-1:0]             cd_ready_o,
    input  logic [DataWidth*NoPorts-1:0]   cd_data_i,
    input  logic [NoPorts-1:0]             cd_last_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [4:0]                     rsp_resp_o,
    output logic [IW-1:0]                  rsp_port_o,
    output logic                           data_valid_o,
    input  logic                           data_ready_i,
    output logic [DataWidth-1:0]           data_o,
    output logic                           data_last_o
);
    localparam int CdBeats = LineWidth / DataWidth;
    localparam int CW = $clog2(CdBeats + 1);

    state_e state;
    logic [NoPorts-1:0] tmask, ac_done, cr_done, dmask;
    logic [CW-1:0] cnt [NoPorts];
    logic [4:0] resp_acc, cr_or;
    logic [NoPorts-1:0] req_t, ac_hs, cr_rdy, cr_hs, cd_rdy, cd_hs;
    logic [NoPorts-1:0] cd_done, cd_done_nxt, cd_last_exp, cr_dt, cr_done_nxt, sel_oh;
    logic [IW-1:0] sel_idx;
    logic last_err, drain, to_hit, fwd;

    ace_snoop_lzc_sel #(.N(NoPorts)) u_sel (
        .vec(dmask),
        .onehot(sel_oh),
        .idx(sel_idx)
    );

    assign fwd = state == FWD_CD;
    assign req_t = req_mask_i & ~(SkipInitiator ? (NoPorts'(1) << req_src_i) : '0);
    assign req_ready_o = state == IDLE;
    assign rsp_valid_o = state == RESP;
    assign rsp_resp_o = rsp_valid_o ? resp_acc : '0;
    assign rsp_port_o = rsp_valid_o ? sel_idx : '0;
    assign ac_valid_o = state == SEND_AC ? tmask & ~ac_done : '0;
    assign ac_hs = ac_valid_o & ac_ready_i;
    assign cr_rdy = state == SEND_AC ? tmask & ac_done & ~cr_done : '0;
    assign cr_hs = cr_rdy & cr_valid_i;
    assign cr_ready_o = cr_rdy | {NoPorts{drain}};
    assign cr_done_nxt = cr_done | cr_hs;
    assign cd_rdy = fwd ? dmask & ~cd_done & (~sel_oh | {NoPorts{data_ready_i}}) : '0;
    assign cd_hs = cd_rdy & cd_valid_i;
    assign cd_ready_o = cd_rdy | {NoPorts{drain}};
    assign data_valid_o = fwd & |(sel_oh & cd_valid_i & ~cd_done);
    assign data_last_o = fwd & |(sel_oh & cd_last_exp & ~cd_done);
    assign data_o = data_valid_o ? cd_data_i[sel_idx*DataWidth +: DataWidth] : '0;

    // per-port beat position: finished, and whether the next beat should carry last
    always_comb begin
        cd_done = '0;
        cd_last_exp = '0;
        for (int p = 0; p < NoPorts; p++) begin
            cd_done[p] = cnt[p] == CW'(CdBeats);
            cd_last_exp[p] = cnt[p] == CW'(CdBeats - 1);
        end
    end

    // merge this cycle's CR handshakes and spot CD last markers that disagree with the count
    always_comb begin
        cr_or = '0;
        cr_dt = '0;
        last_err = 1'b0;
        cd_done_nxt = '0;
        for (int p = 0; p < NoPorts; p++) begin
            cd_done_nxt[p] = cd_done[p] | (cd_hs[p] & cd_last_exp[p]);
            cr_dt[p] = cr_hs[p] & cr_resp_i[5*p + CR_DT];
            cr_or = cr_or | (cr_hs[p] ? cr_resp_i[5*p +: 5] : 5'b0);
            last_err = last_err | (cd_hs[p] & (cd_last_i[p] ^ cd_last_exp[p]));
        end
    end

    // transaction FSM: accept, snoop and collect, forward/drain data, present the merged result
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            tmask <= '0;
            ac_done <= '0;
            cr_done <= '0;
            dmask <= '0;
            resp_acc <= '0;
            ac_addr_o <= '0;
            ac_snoop_o <= '0;
            for (int p = 0; p < NoPorts; p++) cnt[p] <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    ac_addr_o <= req_addr_i;
                    ac_snoop_o <= req_snoop_i;
                    tmask <= req_t;
                    ac_done <= '0;
                    cr_done <= '0;
                    dmask <= '0;
                    resp_acc <= '0;
                    for (int p = 0; p < NoPorts; p++) cnt[p] <= '0;
                    state <= req_t == '0 ? RESP : SEND_AC;
                end
                SEND_AC: begin
                    ac_done <= ac_done | ac_hs;
                    cr_done <= cr_done_nxt;
                    dmask <= dmask | cr_dt;
                    resp_acc <= resp_acc | cr_or;
                    if (cr_done_nxt == tmask) state <= |(dmask | cr_dt) ? FWD_CD : RESP;
                end
                FWD_CD: begin
                    for (int p = 0; p < NoPorts; p++)
                        if (cd_hs[p]) cnt[p] <= cnt[p] + CW'(1);
                    if (last_err) resp_acc[CR_ERR] <= 1'b1;
                    if (&(~dmask | cd_done_nxt)) state <= RESP;
                end
                RESP: if (rsp_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (to_hit) begin
                state <= RESP;
                resp_acc <= 5'b1 << CR_ERR;
                dmask <= '0;
            end
        end
    end

`ifdef ACE_SNOOP_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    assign to_hit = (state == SEND_AC || fwd) && &to_cnt;
    // stall counter restarts on any channel progress; after expiry late CR/CD are swallowed until the next accept
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt <= '0;
            drain <= 1'b0;
        end else begin
            to_cnt <= (state == SEND_AC || fwd) && !(|{ac_hs, cr_hs, cd_hs}) && !to_hit ? to_cnt + TO_W'(1) : '0;
            if (to_hit) drain <= 1'b1;
            else if (req_valid_i && req_ready_o) drain <= 1'b0;
        end
    end
`else
    assign to_hit = 1'b0;
    assign drain = 1'b0;
`endif
endmodule

// File: tb/tb_ace_snoop_collector.sv
// tb_ace_snoop_collector: directed checks of the snoop collector with 4 ports and 8-beat lines
module tb_ace_snoop_collector;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic req_valid_i, req_ready_o;
    logic [63:0] req_addr_i, ac_addr_o, data_o;
    logic [3:0] req_snoop_i, ac_snoop_o, req_mask_i;
    logic [1:0] req_src_i, rsp_port_o;
    logic [3:0] ac_valid_o, ac_ready_i, cr_valid_i, cr_ready_o, cd_valid_i, cd_ready_o, cd_last_i;
    logic [19:0] cr_resp_i;
    logic [255:0] cd_data_i;
    logic rsp_valid_o, rsp_ready_i, data_valid_o, data_ready_i, data_last_o;
    logic [4:0] rsp_resp_o;

    ace_snoop_collector dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_snoop_i(req_snoop_i), .req_src_i(req_src_i), .req_mask_i(req_mask_i),
        .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .ac_addr_o(ac_addr_o), .ac_snoop_o(ac_snoop_o),
        .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
        .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data_i), .cd_last_i(cd_last_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_resp_o(rsp_resp_o), .rsp_port_o(rsp_port_o),
        .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_o(data_o), .data_last_o(data_last_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    logic [4:0] r_resp;
    logic [1:0] r_port;
    int r_cyc, n_beats;
    int cr_cyc [4];
    logic [3:0] ac_seen;
    bit acc_ok, beat_err, mirror_err, addr_err, rst_ok;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs;
        req_valid_i = 1'b0;
        req_addr_i = '0;
        req_snoop_i = '0;
        req_src_i = '0;
        req_mask_i = '0;
        ac_ready_i = '0;
        cr_valid_i = '0;
        cr_resp_i = '0;
        cd_valid_i = '0;
        cd_data_i = '0;
        cd_last_i = '0;
        rsp_ready_i = 1'b1;
        data_ready_i = 1'b0;
    endtask

    task automatic run_txn(input logic [1:0] src, input logic [3:0] mask, input logic [3:0] dt,
                           input logic [19:0] resp_all, input int exp_sel, input int ac_w0,
                           input bit tog, input int bad_port, input int bad_beat, input int rst_at);
        int ac_wait [4];
        bit ac_got [4];
        bit cr_sent [4];
        int beat [4];
        bit done;
        done = 1'b0;
        ac_wait = '{ac_w0, 0, 0, 0};
        ac_got = '{default: 1'b0};
        cr_sent = '{default: 1'b0};
        beat = '{default: 0};
        cr_cyc = '{default: -1};
        r_cyc = -1;
        n_beats = 0;
        r_resp = '1;
        r_port = '1;
        ac_seen = '0;
        acc_ok = 1'b0;
        beat_err = 1'b0;
        mirror_err = 1'b0;
        addr_err = 1'b0;
        rst_ok = 1'b0;
        @(negedge clk_i);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            req_valid_i = cyc == 0;
            req_src_i = src;
            req_mask_i = mask;
            req_addr_i = 64'hA5A5_0000_1234_5678;
            req_snoop_i = 4'h7;
            cr_resp_i = resp_all;
            data_ready_i = tog ? ((cyc % 2) == 1) : 1'b1;
            for (int p = 0; p < 4; p++) begin
                ac_ready_i[p] = ac_wait[p] == 0;
                cr_valid_i[p] = ac_got[p] && !cr_sent[p];
                cd_valid_i[p] = dt[p] && cr_sent[p] && beat[p] < 8;
                cd_data_i[p*64 +: 64] = 64'((p << 8) | beat[p]);
                cd_last_i[p] = beat[p] == (p == bad_port ? bad_beat : 7);
            end
            if (cyc == rst_at) rst_i = 1'b1;
            #1;
            if (cyc == rst_at) begin
                rst_ok = {ac_valid_o, cr_ready_o, cd_ready_o, data_valid_o, data_last_o, rsp_valid_o,
                          rsp_resp_o, rsp_port_o, data_o} == '0 && req_ready_o;
                done = 1'b1;
            end else begin
                if (cyc == 0) acc_ok = req_ready_o;
                ac_seen = ac_seen | ac_valid_o;
                if (|ac_valid_o && (ac_addr_o != req_addr_i || ac_snoop_o != req_snoop_i)) addr_err = 1'b1;
                for (int p = 0; p < 4; p++) begin
                    if (ac_valid_o[p] && !ac_ready_i[p]) ac_wait[p]--;
                    if (ac_valid_o[p] && ac_ready_i[p]) ac_got[p] = 1'b1;
                    if (cr_valid_i[p] && cr_ready_o[p]) begin
                        cr_sent[p] = 1'b1;
                        cr_cyc[p] = cyc;
                    end
                    if (cd_valid_i[p] && cd_ready_o[p]) beat[p]++;
                end
                if (data_valid_o) begin
                    if (cd_ready_o[exp_sel] != data_ready_i) mirror_err = 1'b1;
                    if (data_ready_i) begin
                        if (data_o != 64'((exp_sel << 8) | n_beats) || data_last_o != (n_beats == 7)) beat_err = 1'b1;
                        n_beats++;
                    end
                end
                if (rsp_valid_o) begin
                    r_resp = rsp_resp_o;
                    r_port = rsp_port_o;
                    r_cyc = cyc;
                    done = 1'b1;
                end
            end
            @(negedge clk_i);
        end
        clear_inputs();
        rst_i = 1'b0;
    endtask

    initial begin
        clear_inputs();
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_req_ready", 64'(req_ready_o), 64'(1));
        check("rst_outputs", 64'({ac_valid_o, cr_ready_o, cd_ready_o, data_valid_o, rsp_valid_o, rsp_resp_o}), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b0;

        run_txn(2'd1, 4'hF, 4'h0, 20'h0, 0, 0, 1'b0, -1, 7, -1);
        check("nodata_accept", 64'(acc_ok), 64'(1));
        check("nodata_ac_ports", 64'(ac_seen), 64'(4'b1101));
        check("nodata_ac_stable", 64'(addr_err), 64'(0));
        check("nodata_resp", 64'(r_resp), 64'(0));
        check("nodata_beats", 64'(n_beats), 64'(0));
        check("nodata_latency", 64'(r_cyc), 64'(3));

        run_txn(2'd1, 4'b0010, 4'h0, 20'h0, 0, 0, 1'b0, -1, 7, -1);
        check("empty_mask_latency", 64'(r_cyc), 64'(1));
        check("empty_mask_resp", 64'(r_resp), 64'(0));
        check("empty_mask_no_ac", 64'(ac_seen), 64'(0));

        run_txn(2'd1, 4'hF, 4'b1100, {5'b01001, 5'b00001, 5'b0, 5'b0}, 2, 0, 1'b0, -1, 7, -1);
        check("fwd_resp", 64'(r_resp), 64'(5'b01001));
        check("fwd_port", 64'(r_port), 64'(2));
        check("fwd_beats", 64'(n_beats), 64'(8));
        check("fwd_beat_data", 64'(beat_err), 64'(0));
        check("fwd_latency", 64'(r_cyc), 64'(11));

        run_txn(2'd1, 4'hF, 4'h0, 20'h0, 0, 5, 1'b0, -1, 7, -1);
        check("slow_ac_cr2_cycle", 64'(cr_cyc[2]), 64'(2));
        check("slow_ac_cr0_cycle", 64'(cr_cyc[0]), 64'(7));
        check("slow_ac_latency", 64'(r_cyc), 64'(8));
        check("slow_ac_resp", 64'(r_resp), 64'(0));

        run_txn(2'd0, 4'hF, 4'b0010, {5'b0, 5'b0, 5'b00101, 5'b0}, 1, 0, 1'b1, -1, 7, -1);
        check("toggle_beats", 64'(n_beats), 64'(8));
        check("toggle_beat_data", 64'(beat_err), 64'(0));
        check("toggle_ready_mirror", 64'(mirror_err), 64'(0));
        check("toggle_resp", 64'(r_resp), 64'(5'b00101));
        check("toggle_port", 64'(r_port), 64'(1));
        check("toggle_latency", 64'(r_cyc), 64'(18));

        run_txn(2'd1, 4'hF, 4'b1100, {5'b00001, 5'b00001, 10'b0}, 2, 0, 1'b0, 3, 5, -1);
        check("bad_last_resp", 64'(r_resp), 64'(5'b00011));
        check("bad_last_port", 64'(r_port), 64'(2));
        check("bad_last_beats", 64'(n_beats), 64'(8));

        run_txn(2'd1, 4'hF, 4'b1100, {5'b00001, 5'b00001, 10'b0}, 2, 0, 1'b0, -1, 7, 5);
        check("mid_reset_outputs", 64'(rst_ok), 64'(1));
        run_txn(2'd1, 4'hF, 4'h0, 20'h0, 0, 0, 1'b0, -1, 7, -1);
        check("after_reset_latency", 64'(r_cyc), 64'(3));
        check("after_reset_resp", 64'(r_resp), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
